// File: rtl/bus_rr_xbar_pkg.sv
// Shared types and width helpers for the round-robin host/device crossbar.
package bus_rr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    ERR_RSP
  } state_e;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_xbar_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping, wins.
module rr_arbiter
  import bus_rr_pkg::*;
#(
  parameter int NrHosts = 2,
  localparam int HW = idx_w(NrHosts)
) (
  input  logic [NrHosts-1:0] req,
  input  logic [HW-1:0]      ptr,
  output logic [NrHosts-1:0] gnt,
  output logic [HW-1:0]      idx,
  output logic               valid
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < NrHosts; i++) begin
      j = (int'(ptr) + i) % NrHosts;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = HW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_xbar.sv
// Multi-host, multi-device data bus: round-robin grant, one transaction in
// flight, local decode-error and timeout responses.
module bus_rr_xbar
  import bus_rr_pkg::*;
#(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 3,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NrHosts-1:0]                       host_req_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrDevices-1:0]                     device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
  output logic [NrDevices-1:0]                     device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  input  logic [NrDevices-1:0]                     device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask_i
);

  localparam int HW   = idx_w(NrHosts);
  localparam int DevW = idx_w(NrDevices);
  localparam int CW   = cnt_w(TimeoutCycles);
  localparam int BW   = DataWidth / 8;
  localparam logic [CW-1:0] TmoLast =
    (TimeoutCycles > 0) ? CW'(TimeoutCycles - 1) : '0;

  state_e state_q, state_d;
  logic [HW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]   host_q, host_d;
  logic [DevW-1:0] dev_q, dev_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NrHosts-1:0] arb_req, arb_gnt;
  logic [HW-1:0]      arb_idx;
  logic               arb_valid;

  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BW-1:0]           win_be;
  logic [DataWidth-1:0]    win_wdata;

  logic                 dec_hit;
  logic [DevW-1:0]      dec_idx;
  logic                 dev_fire;
  logic                 sel_rvalid, sel_err;
  logic [DataWidth-1:0] sel_rdata;
  logic                 rsp_valid, rsp_err;
  logic [DataWidth-1:0] rsp_data;
  logic                 tmo;

  assign arb_req = (state_q == IDLE) ? host_req_i : '0;

  rr_arbiter #(
    .NrHosts (NrHosts)
  ) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (arb_gnt[h]) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  // Walk downward so the lowest hitting device index is the one kept.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask_i[d])
          == cfg_device_addr_base_i[d]) begin
        dec_hit = 1'b1;
        dec_idx = DevW'(d);
      end
    end
  end

  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    sel_err    = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (dev_q == DevW'(d)) begin
        sel_rvalid = device_rvalid_i[d];
        sel_rdata  = device_rdata_i[d];
        sel_err    = device_err_i[d];
      end
    end
  end

  assign tmo = (TimeoutCycles != 0) && (cnt_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    host_d     = host_q;
    dev_d      = dev_q;
    cnt_d      = cnt_q;
    host_gnt_o = '0;
    dev_fire   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          host_gnt_o = arb_gnt;
          host_d     = arb_idx;
          rr_ptr_d   = (arb_idx == HW'(NrHosts - 1)) ? '0 : arb_idx + 1'b1;
          if (dec_hit) begin
            dev_fire = 1'b1;
            dev_d    = dec_idx;
            cnt_d    = '0;
            state_d  = WAIT_RSP;
          end else begin
            state_d  = ERR_RSP;
          end
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        if (sel_rvalid) begin
          rsp_valid = 1'b1;
          rsp_data  = sel_rdata;
          rsp_err   = sel_err;
          state_d   = IDLE;
        end else if (tmo) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          state_d   = IDLE;
        end
      end
      ERR_RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences the bus in the same cycle it is asserted.
    if (rst_i) begin
      host_gnt_o = '0;
      dev_fire   = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      rsp_err    = 1'b0;
    end
  end

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = dev_fire && (dec_idx == DevW'(d));
      device_addr_o[d]  = win_addr;
      device_we_o[d]    = win_we;
      device_be_o[d]    = win_be;
      device_wdata_o[d] = win_wdata;
    end
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = rsp_valid && (host_q == HW'(h));
      host_rdata_o[h]  = host_rvalid_o[h] ? rsp_data : '0;
      host_err_o[h]    = host_rvalid_o[h] && rsp_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      host_q   <= '0;
      dev_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      host_q   <= host_d;
      dev_q    <= dev_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed bench for bus_rr_xbar: device latency model plus response
// scoreboard keyed by host, data, error and arrival cycle.
module tb_bus_rr_xbar;

  localparam int NH = 2;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_i;
  logic [NH-1:0]        host_req_i, host_gnt_o, host_we_i;
  logic [NH-1:0][31:0]  host_addr_i, host_wdata_i, host_rdata_o;
  logic [NH-1:0][3:0]   host_be_i;
  logic [NH-1:0]        host_rvalid_o, host_err_o;
  logic [ND-1:0]        device_req_o, device_we_o;
  logic [ND-1:0][31:0]  device_addr_o, device_wdata_o, device_rdata_i;
  logic [ND-1:0][3:0]   device_be_o;
  logic [ND-1:0]        device_rvalid_i, device_err_i;
  logic [ND-1:0][31:0]  cfg_base, cfg_mask;

  bus_rr_xbar #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(32),
    .AddressWidth(32), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
    .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o),
    .device_we_o(device_we_o), .device_be_o(device_be_o),
    .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } dev_t;

  exp_t sb[$];
  dev_t dq[ND][$];
  int   lat[ND] = '{1, 5, -1};
  logic dev_err[ND];

  int n_pass = 0;
  int n_total = 0;
  int n = 0;
  int g;

  logic [NH-1:0]  gnt_s, rv_s, err_s;
  logic [63:0]    rd_s;
  logic [ND-1:0]  dreq_s;
  logic           d0_we_s;
  logic [3:0]     d0_be_s;
  logic [31:0]    d0_wdata_s, d0_addr_s;

  function automatic logic [31:0] dev_data(int d, logic [31:0] a);
    return a ^ (32'hC0DE_0000 + 32'(d) * 32'h1111);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One bus cycle: drive device responses, sample at negedge, advance.
  task automatic cyc();
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 1'b0;
      device_err_i[d]    = 1'b0;
      device_rdata_i[d]  = 32'hBAD0_0000 | 32'(d);
      if (dq[d].size() > 0 && dq[d][0].cyc == n) begin
        device_rvalid_i[d] = 1'b1;
        device_err_i[d]    = dev_err[d];
        device_rdata_i[d]  = dev_data(d, dq[d][0].addr);
        void'(dq[d].pop_front());
      end
    end
    @(negedge clk);
    gnt_s      = host_gnt_o;
    rv_s       = host_rvalid_o;
    err_s      = host_err_o;
    rd_s       = host_rdata_o;
    dreq_s     = device_req_o;
    d0_we_s    = device_we_o[0];
    d0_be_s    = device_be_o[0];
    d0_wdata_s = device_wdata_o[0];
    d0_addr_s  = device_addr_o[0];
    for (int d = 0; d < ND; d++)
      if (device_req_o[d] && lat[d] > 0)
        dq[d].push_back('{n + lat[d], device_addr_o[d]});
    for (int h = 0; h < NH; h++) begin
      if (host_rvalid_o[h]) begin
        chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_host", h, e.host);
          chk("rsp_cycle", n, e.cyc);
          chk("rsp_rdata", host_rdata_o[h], e.rdata);
          chk("rsp_err", host_err_o[h], e.err);
        end
      end
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    rst_i           = 1'b1;
    host_req_i      = '0;
    host_we_i       = '0;
    host_addr_i     = '0;
    host_wdata_i    = '0;
    host_be_i       = {4'hF, 4'hF};
    device_rvalid_i = '0;
    device_rdata_i  = '0;
    device_err_i    = '0;
    dev_err         = '{1'b0, 1'b0, 1'b0};
    cfg_base = {32'h0003_0000, 32'h0002_0000, 32'h0010_0000};
    cfg_mask = {32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFF0_0000};
    @(posedge clk);
    #1;

    // Reset: outputs silent even with requests pending
    host_req_i  = 2'b11;
    host_addr_i = {32'h0010_0020, 32'h0010_0010};
    cyc();
    chk("rst_gnt", gnt_s, 0);
    chk("rst_dreq", dreq_s, 0);
    chk("rst_rvalid", rv_s, 0);
    chk("rst_rdata", rd_s, 0);
    rst_i = 1'b0;

    // 1: both hosts hammer RAM, grants alternate
    g = n;
    for (int k = 0; k < 4; k++)
      sb.push_back('{k % 2, dev_data(0, host_addr_i[k % 2]), 1'b0,
                     g + 2 * k + 1});
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t1_gnt", gnt_s,
          (k % 2 == 0) ? 64'(1 << ((k / 2) % 2)) : 64'd0);
    end
    host_req_i = '0;

    // 2: host 0 reads SimCtrl (5-cycle latency), stray RAM rvalid ignored
    g = n;
    host_req_i     = 2'b01;
    host_addr_i[0] = 32'h0002_0000;
    sb.push_back('{0, dev_data(1, 32'h0002_0000), 1'b0, g + 5});
    dq[0].push_back('{g + 2, 32'h0000_0000});
    cyc();
    chk("t2_gnt", gnt_s, 2'b01);
    chk("t2_dreq", dreq_s, 3'b010);
    host_req_i     = 2'b10;
    host_addr_i[1] = 32'h0000_4000;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t2_no_gnt", gnt_s, 0);
    end

    // 3: host 1 hits an unmapped address
    sb.push_back('{1, 32'h0, 1'b1, g + 7});
    cyc();
    chk("t3_gnt", gnt_s, 2'b10);
    chk("t3_no_dreq", dreq_s, 0);
    host_req_i = '0;
    cyc();

    // 6: write to RAM answered with a device error
    host_req_i      = 2'b01;
    host_we_i       = 2'b01;
    host_be_i[0]    = 4'b0011;
    host_wdata_i[0] = 32'hDEAD_BEEF;
    host_addr_i[0]  = 32'h0010_0100;
    dev_err[0]      = 1'b1;
    sb.push_back('{0, dev_data(0, 32'h0010_0100), 1'b1, n + 1});
    cyc();
    chk("t6_gnt", gnt_s, 2'b01);
    chk("t6_dreq", dreq_s, 3'b001);
    chk("t6_we", d0_we_s, 1'b1);
    chk("t6_be", d0_be_s, 4'b0011);
    chk("t6_wdata", d0_wdata_s, 32'hDEAD_BEEF);
    chk("t6_addr", d0_addr_s, 32'h0010_0100);
    host_req_i = '0;
    cyc();
    dev_err[0]   = 1'b0;
    host_we_i    = '0;
    host_be_i[0] = 4'hF;

    // 4: timer never answers, timeout 8 cycles after grant
    g = n;
    host_req_i     = 2'b10;
    host_addr_i[1] = 32'h0003_0004;
    sb.push_back('{1, 32'h0, 1'b1, g + 8});
    cyc();
    chk("t4_gnt", gnt_s, 2'b10);
    chk("t4_dreq", dreq_s, 3'b100);
    host_req_i     = 2'b01;
    host_addr_i[0] = 32'h0003_0008;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("t4_no_gnt", gnt_s, 0);
    end
    cyc();
    chk("t4_regrant", gnt_s, 2'b01);
    chk("t4_regrant_dreq", dreq_s, 3'b100);

    // 5: reset while waiting drops the transaction and rewinds rr_ptr
    host_req_i = 2'b11;
    cyc();
    chk("t5_wait_gnt", gnt_s, 0);
    rst_i = 1'b1;
    cyc();
    chk("t5_rst_gnt", gnt_s, 0);
    chk("t5_rst_dreq", dreq_s, 0);
    chk("t5_rst_rvalid", rv_s, 0);
    chk("t5_rst_err", err_s, 0);
    rst_i = 1'b0;
    g = n;
    host_addr_i = {32'h0010_0040, 32'h0010_0030};
    sb.push_back('{0, dev_data(0, 32'h0010_0030), 1'b0, g + 1});
    sb.push_back('{1, dev_data(0, 32'h0010_0040), 1'b0, g + 3});
    cyc();
    chk("t5_first_gnt", gnt_s, 2'b01);
    cyc();
    chk("t5_gap", gnt_s, 0);
    cyc();
    chk("t5_second_gnt", gnt_s, 2'b10);
    host_req_i = '0;
    cyc();
    cyc();

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
